// File: rtl/mod5_up_down_counter.sv
// Modulo-5 up/down counter with enable and synchronous reset.
// Out-of-range states 5..7 recover to 0 on the next edge.
module mod5_up_down_counter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_up_down,
    output logic [2:0] o_Q
);

    localparam logic [2:0] MAX_CNT = 3'd4;

    logic [2:0] count_q;
    logic [2:0] count_d;
    logic       illegal;

    assign illegal = (count_q > MAX_CNT);

    // Next count: recovery, then enable, then direction; wrap at 0 and 4.
    always_comb begin
        count_d = count_q;
        if (illegal) begin
            count_d = 3'd0;
        end else if (i_en) begin
            if (i_up_down) begin
                count_d = (count_q == 3'd0) ? MAX_CNT : (count_q - 3'd1);
            end else begin
                count_d = (count_q == MAX_CNT) ? 3'd0 : (count_q + 3'd1);
            end
        end
    end

    // Count register; reset is synchronous and overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Q = count_q;

endmodule

// File: tb/tb_mod5_up_down_counter.sv
// Self-checking bench for mod5_up_down_counter.
// Directed scenarios followed by random stimulus against a modulo-5 model.
module tb_mod5_up_down_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ud;
    logic [2:0] q;

    int n_cmp;
    int n_bad;
    int model;

    mod5_up_down_counter dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_up_down (ud),
        .o_Q       (q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string tag, input int exp);
        n_cmp++;
        assert (q === 3'(exp)) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, q, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic d,
                        input string tag);
        @(negedge clk);
        rst = r;
        en  = e;
        ud  = d;
        @(posedge clk);
        if (r) model = 0;
        else if (e) model = d ? (model + 4) % 5 : (model + 1) % 5;
        #1;
        cmp(tag, model);
    endtask

    int up_exp[6]  = '{1, 2, 3, 4, 0, 1};
    int dn_exp[4]  = '{0, 4, 3, 2};
    int rev_exp[3] = '{1, 0, 4};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model = 0;
        rst = 1'b1;
        en  = 1'b0;
        ud  = 1'b0;

        step(1, 0, 0, "reset");
        cmp("reset_const", 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, "idle_after_reset");
            cmp("idle_const", 0);
        end

        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, "up_wrap");
            cmp("up_const", up_exp[i]);
        end

        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, "down_wrap");
            cmp("down_const", dn_exp[i]);
        end

        step(0, 1, 0, "to_three");
        cmp("to_three_const", 3);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1'(i % 2), "hold");
            cmp("hold_const", 3);
        end

        step(0, 1, 0, "to_four");
        cmp("to_four_const", 4);
        step(1, 1, 0, "mid_reset");
        cmp("mid_reset_const", 0);
        step(0, 1, 0, "post_reset1");
        cmp("post_reset1_const", 1);
        step(0, 1, 0, "post_reset2");
        cmp("post_reset2_const", 2);

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, "reverse");
            cmp("reverse_const", rev_exp[i]);
        end

        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        ud  = 1'b1;
        #2;
        cmp("no_async_reset", 4);
        @(posedge clk);
        model = 0;
        #1;
        cmp("reset_down_at_four", 0);
        step(1, 1, 0, "reset_held");
        cmp("reset_held_const", 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(15) == 0), 1'($urandom),
                 1'($urandom), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
